// File: rtl/sb_pkg.sv
// Shared defaults and bypass-tap indices for the decode-stage operand scoreboard.
package sb_pkg;
  localparam int SB_AW  = 5;
  localparam int SB_DW  = 32;
  localparam int TAP_EX = 0;
  localparam int TAP_ME = 1;
  localparam int TAP_WB = 2;
endpackage

// File: rtl/operand_select.sv
// Resolves one decode source from the bypass taps, commit write-through, or regfile.
// Stalls when the youngest matching producer is not ready or sits outside the bypass network.
module operand_select
  import sb_pkg::*;
#(
  parameter int AW     = SB_AW,
  parameter int DW     = SB_DW,
  parameter int NSTAGE = 3
) (
  input  logic                 src_valid,
  input  logic [AW-1:0]        src_addr,
  input  logic [DW-1:0]        rf_rdata,
  input  logic [NSTAGE-1:0]    byp_valid,
  input  logic [NSTAGE*AW-1:0] byp_dest,
  input  logic [NSTAGE-1:0]    byp_ready,
  input  logic [NSTAGE*DW-1:0] byp_data,
  input  logic                 cmt_we,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [DW-1:0]        cmt_data,
  input  logic                 pend_busy,
  output logic [DW-1:0]        src_value,
  output logic                 src_stall
);

  logic          hit;
  logic          hit_ready;
  logic [DW-1:0] hit_data;

  // First match from the EX side is the youngest producer.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    for (int k = TAP_EX; k < NSTAGE; k++) begin
      if (!hit && byp_valid[k] && (byp_dest[k*AW +: AW] == src_addr)) begin
        hit       = 1'b1;
        hit_ready = byp_ready[k];
        hit_data  = byp_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    src_value = rf_rdata;
    src_stall = 1'b0;
    if (src_valid) begin
      if (src_addr == '0) begin
        src_value = '0;
      end else if (hit) begin
        if (hit_ready) src_value = hit_data;
        else           src_stall = 1'b1;
      end else if (cmt_we && (cmt_addr == src_addr)) begin
        src_value = cmt_data;
      end else if (pend_busy) begin
        src_stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_scoreboard.sv
// Decode-stage operand hazard unit: per-register pending-write counters plus
// one operand_select per source port.
module operand_scoreboard
  import sb_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int AW     = SB_AW,
  parameter int DW     = SB_DW,
  parameter int NSRC   = 3,
  parameter int NSTAGE = 3,
  parameter int CW     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC*DW-1:0]   rf_rdata,
  output logic [NSRC*DW-1:0]   src_value,
  output logic                 stall,
  input  logic [NSTAGE-1:0]    byp_valid,
  input  logic [NSTAGE*AW-1:0] byp_dest,
  input  logic [NSTAGE-1:0]    byp_ready,
  input  logic [NSTAGE*DW-1:0] byp_data,
  input  logic                 issue_fire,
  input  logic                 issue_we,
  input  logic [AW-1:0]        issue_dest,
  output logic                 issue_ready,
  input  logic                 cmt_we,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [DW-1:0]        cmt_data,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec
);

  localparam logic [CW-1:0] PEND_MAX = '1;

  logic [CW-1:0]   pend_q [NREGS];
  logic [CW-1:0]   pend_d [NREGS];
  logic            issue_eff;
  logic            ovf_err;
  logic            unf_err;
  logic [NSRC-1:0] src_stall;

  assign issue_eff = issue_fire && issue_we && !flush && (issue_dest != '0);

  // Issue and commit to the same register cancel; flush drops every uncommitted writer.
  always_comb begin
    pend_d  = pend_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;
    pend_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        pend_d[r] = '0;
      end else if (issue_eff && (issue_dest == AW'(r)) &&
                   !(cmt_we && (cmt_addr == AW'(r)))) begin
        if (pend_q[r] == PEND_MAX) ovf_err = 1'b1;
        else                       pend_d[r] = pend_q[r] + CW'(1);
      end else if (cmt_we && (cmt_addr == AW'(r)) &&
                   !(issue_eff && (issue_dest == AW'(r)))) begin
        if (pend_q[r] == '0) unf_err = 1'b1;
        else                 pend_d[r] = pend_q[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      assert (!ovf_err);
      assert (!unf_err);
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREGS; r++) busy_vec[r] = (pend_q[r] != '0);
  end

  assign issue_ready = (pend_q[issue_dest] != PEND_MAX);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    operand_select #(
      .AW    (AW),
      .DW    (DW),
      .NSTAGE(NSTAGE)
    ) u_sel (
      .src_valid(src_valid[i]),
      .src_addr (src_addr[i*AW +: AW]),
      .rf_rdata (rf_rdata[i*DW +: DW]),
      .byp_valid(byp_valid),
      .byp_dest (byp_dest),
      .byp_ready(byp_ready),
      .byp_data (byp_data),
      .cmt_we   (cmt_we),
      .cmt_addr (cmt_addr),
      .cmt_data (cmt_data),
      .pend_busy(pend_q[src_addr[i*AW +: AW]] != '0),
      .src_value(src_value[i*DW +: DW]),
      .src_stall(src_stall[i])
    );
  end

  assign stall = |src_stall;

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_operand_scoreboard;

  localparam int KIND_VAL   = 0;
  localparam int KIND_STALL = 1;
  localparam int KIND_RDY   = 2;
  localparam int KIND_BUSY  = 3;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_valid;
  logic [14:0] src_addr;
  logic [95:0] rf_rdata;
  logic [95:0] src_value;
  logic        stall;
  logic [2:0]  byp_valid;
  logic [14:0] byp_dest;
  logic [2:0]  byp_ready;
  logic [95:0] byp_data;
  logic        issue_fire;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic        cmt_we;
  logic [4:0]  cmt_addr;
  logic [31:0] cmt_data;
  logic        flush;
  logic [31:0] busy_vec;

  sb_item_t sbq[$];
  sb_item_t mon_item;
  logic [31:0] got;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_scoreboard dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_addr(src_addr), .rf_rdata(rf_rdata),
    .src_value(src_value), .stall(stall),
    .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_ready(byp_ready), .byp_data(byp_data),
    .issue_fire(issue_fire), .issue_we(issue_we), .issue_dest(issue_dest),
    .issue_ready(issue_ready),
    .cmt_we(cmt_we), .cmt_addr(cmt_addr), .cmt_data(cmt_data),
    .flush(flush), .busy_vec(busy_vec)
  );

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_item = sbq.pop_front();
      case (mon_item.kind)
        KIND_VAL:   got = src_value[mon_item.idx*32 +: 32];
        KIND_STALL: got = {31'd0, stall};
        KIND_RDY:   got = {31'd0, issue_ready};
        default:    got = busy_vec;
      endcase
      checks++;
      if (got !== mon_item.exp) begin
        errors++;
        $display("FAIL %s got %h expected %h", mon_item.name, got, mon_item.exp);
      end
    end
  end

  task automatic push(input string n, input int kind, input int idx, input logic [31:0] e);
    sb_item_t it;
    it.name = n; it.kind = kind; it.idx = idx; it.exp = e;
    sbq.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    src_valid = '0; src_addr = '0;
    rf_rdata = {32'hF00D_0002, 32'hF00D_0001, 32'hF00D_0000};
    byp_valid = '0; byp_dest = '0; byp_ready = '0; byp_data = '0;
    issue_fire = 1'b0; issue_we = 1'b0; issue_dest = '0;
    cmt_we = 1'b0; cmt_addr = '0; cmt_data = '0; flush = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a);
    src_valid[i] = 1'b1;
    src_addr[i*5 +: 5] = a;
  endtask

  task automatic set_tap(input int k, input logic [4:0] d, input logic rdy, input logic [31:0] data);
    byp_valid[k] = 1'b1;
    byp_dest[k*5 +: 5] = d;
    byp_ready[k] = rdy;
    byp_data[k*32 +: 32] = data;
  endtask

  task automatic issue(input logic [4:0] d);
    issue_fire = 1'b1; issue_we = 1'b1; issue_dest = d;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] data);
    cmt_we = 1'b1; cmt_addr = a; cmt_data = data;
  endtask

  initial begin
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;

    // reset state
    step();
    push("rst_busy", KIND_BUSY, 0, 32'h0);
    push("rst_stall", KIND_STALL, 0, 32'd0);
    push("rst_ready", KIND_RDY, 0, 32'd1);

    // forward from EX
    step(); issue(5'd5);
    push("fwd_issue_ready", KIND_RDY, 0, 32'd1);
    step(); set_src(0, 5'd5); set_tap(0, 5'd5, 1'b1, 32'h1234_5678);
    push("fwd_value", KIND_VAL, 0, 32'h1234_5678);
    push("fwd_stall", KIND_STALL, 0, 32'd0);
    push("fwd_busy", KIND_BUSY, 0, 32'h0000_0020);
    step(); commit(5'd5, 32'h1234_5678);
    step();
    push("fwd_busy_clear", KIND_BUSY, 0, 32'h0);

    // load-use
    step(); issue(5'd7);
    step(); set_src(1, 5'd7); set_tap(0, 5'd7, 1'b0, 32'hDEAD_BEEF);
    push("lu_stall", KIND_STALL, 0, 32'd1);
    step(); set_src(1, 5'd7); set_tap(1, 5'd7, 1'b1, 32'h0000_00AB);
    push("lu_value", KIND_VAL, 1, 32'h0000_00AB);
    push("lu_nostall", KIND_STALL, 0, 32'd0);
    step(); commit(5'd7, 32'h0000_00AB);

    // youngest producer wins, even when it is not ready
    step(); set_src(0, 5'd3); set_tap(0, 5'd3, 1'b1, 32'd1); set_tap(2, 5'd3, 1'b1, 32'd2);
    push("young_value", KIND_VAL, 0, 32'd1);
    push("young_stall", KIND_STALL, 0, 32'd0);
    step(); set_src(2, 5'd3); set_tap(1, 5'd3, 1'b0, 32'd1); set_tap(2, 5'd3, 1'b1, 32'd2);
    push("young_notready_stall", KIND_STALL, 0, 32'd1);

    // out-of-band divider
    step(); issue(5'd9);
    for (int c = 0; c < 10; c++) begin
      step(); set_src(0, 5'd9);
      push("div_stall", KIND_STALL, 0, 32'd1);
    end
    step(); src_addr[4:0] = 5'd9;
    push("div_invalid_nostall", KIND_STALL, 0, 32'd0);
    push("div_invalid_value", KIND_VAL, 0, 32'hF00D_0000);
    step(); set_src(0, 5'd9); commit(5'd9, 32'h55);
    push("div_wt_value", KIND_VAL, 0, 32'h55);
    push("div_wt_stall", KIND_STALL, 0, 32'd0);
    step(); set_src(0, 5'd9);
    push("div_busy_clear", KIND_BUSY, 0, 32'h0);
    push("div_rf_value", KIND_VAL, 0, 32'hF00D_0000);

    // counter limits on r4
    for (int c = 0; c < 7; c++) begin
      step(); issue(5'd4);
      push("lim_ready_fill", KIND_RDY, 0, 32'd1);
    end
    step(); issue_dest = 5'd4;
    push("lim_ready_full", KIND_RDY, 0, 32'd0);
    step(); commit(5'd4, 32'd0);
    step(); issue(5'd4); commit(5'd4, 32'd0);
    push("lim_ready_six", KIND_RDY, 0, 32'd1);
    step(); issue(5'd4);
    push("lim_ready_same", KIND_RDY, 0, 32'd1);
    step(); issue_dest = 5'd4;
    push("lim_ready_full_again", KIND_RDY, 0, 32'd0);
    for (int c = 0; c < 7; c++) begin
      step(); commit(5'd4, 32'd0);
    end
    step();
    push("lim_drained", KIND_BUSY, 0, 32'h0);

    // flush and r0
    step(); issue(5'd2);
    step(); issue(5'd6);
    step();
    push("fl_busy_set", KIND_BUSY, 0, 32'h0000_0044);
    flush = 1'b1; issue(5'd10);
    step();
    push("fl_busy_clear", KIND_BUSY, 0, 32'h0);
    set_src(0, 5'd0); set_tap(0, 5'd0, 1'b0, 32'hCAFE_CAFE);
    push("r0_value", KIND_VAL, 0, 32'h0);
    push("r0_stall", KIND_STALL, 0, 32'd0);

    step(); step();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Parametrised operand-hazard unit for the decode stage of the in-order LoongArch pipeline. It tracks in-flight register writes with per-register pending counters, replacing fixed per-stage destination compares. For every decode source it selects the youngest valid forwarding result. It raises a stall when the youngest producer's result is not yet ready (load in EX, divider busy) or when the producer is outside the bypass network. Sits between the decode logic, the regfile read ports and the EX/ME/WB bypass taps.

## Interface
Parameters
- NREGS, 32: architectural registers; r0 hardwired zero.
- AW, 5: register address width, equal to clog2(NREGS).
- DW, 32: data width.
- NSRC, 3: decode source ports (rj, rk, rd).
- NSTAGE, 3: bypass taps; index 0 is youngest (EX), NSTAGE-1 is oldest (WB).
- CW, 3: pending-counter width; max in-flight writes per register is 2^CW-1.

Ports
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- src_valid  in  NSRC  source i is read by the current decode instruction
- src_addr  in  NSRC*AW  source register numbers
- rf_rdata  in  NSRC*DW  regfile read data, same order as src_addr
- src_value  out  NSRC*DW  resolved operand values
- stall  out  1  decode must hold; at least one valid source is unresolved
- byp_valid  in  NSTAGE  tap holds a register-writing instruction
- byp_dest  in  NSTAGE*AW  tap destination register
- byp_ready  in  NSTAGE  tap result available this cycle
- byp_data  in  NSTAGE*DW  tap result
- issue_fire  in  1  decode hands an instruction to EX this cycle
- issue_we  in  1  issued instruction writes a register
- issue_dest  in  AW  issued destination register
- issue_ready  out  1  counter of issue_dest is below max
- cmt_we  in  1  regfile write this cycle
- cmt_addr  in  AW  regfile write address
- cmt_data  in  DW  regfile write data
- flush  in  1  all uncommitted writers are squashed
- busy_vec  out  NREGS  bit r set when pending[r] != 0

## Operation
- Counter update: pending[r] increments on issue_fire & issue_we & issue_dest==r. It decrements on cmt_we & cmt_addr==r. When both happen to the same register in one cycle, the count is unchanged. Register 0 is never counted.
- flush: every counter is cleared, except that a commit in the same cycle is still written to the regfile. Issue in a flush cycle is ignored.
- Resolution per source i, when src_valid[i] and src_addr != 0:
  - If a tap k has byp_valid & byp_dest==addr, the lowest such k wins.
  - If that winning tap is ready, src_value = byp_data[k], no stall. If it is not ready, stall.
  - If no tap matches and cmt_we & cmt_addr==addr, src_value = cmt_data (write-through).
  - If no tap matches, there is no commit, and pending != 0, stall (producer is outside the bypass network).
  - Otherwise src_value = rf_rdata.
- src_addr == 0 always gives src_value = 0 and never stalls. An invalid source never stalls, and its src_value = rf_rdata.
- stall is the OR over all sources.
- issue_ready is low when pending[issue_dest] == 2^CW-1. The caller must not assert issue_fire while issue_ready is low. An overflow or underflow is an assertion failure, and the counter saturates.

## Timing
- src_value, stall and issue_ready are combinational from the inputs and the current counters. Zero latency.
- Counters and busy_vec update on the rising clk edge and are visible the next cycle.
- Reset: all counters are 0 and busy_vec is 0. stall is 0 and issue_ready is 1 while the inputs are idle.
- Reset has priority over flush, issue and commit. Reset mid-operation discards all in-flight state.
- Stall does not block the counter update; the caller gates issue_fire with !stall.

## Structure
- Shared package sb_pkg holds the AW/DW defaults and the tap index constants TAP_EX=0, TAP_ME=1, TAP_WB=2.
- Sub-module operand_select (one instance per source, NSRC copies) contains the priority match, the ready check and the value mux.
- The counter array lives in the top module.

## Test plan
- Forward from EX: issue add to r5, then at decode rj=r5 with tap0 valid, ready, data 0x12345678. Expected: src_value[0]=0x12345678, stall=0.
- Load-use: tap0 dest r7, ready=0, decode rk=r7. Expected: stall=1 for that cycle. Next cycle the load is on tap1 with ready=1 and data 0xAB. Expected: stall=0, value 0xAB.
- Youngest wins: tap0 and tap2 both dest r3, both ready, data 1 and 2. Expected: value 1.
- Out-of-band divider: issue div r9, with no tap matching r9 for 10 cycles. Expected: stall=1 throughout. A commit of r9 with data 0x55 then gives value 0x55 and stall=0 in the commit cycle, and busy_vec[9]=0 the next cycle.
- Counter limits: issue r4 seven times with CW=3. Expected: issue_ready=0 on the eighth attempt. Issue plus commit of r4 in the same cycle leaves the count unchanged.
- flush and r0: set busy on r2 and r6, then pulse flush. Expected: busy_vec=0 next cycle. rj=r0 with tap0 dest 0 and ready=0 gives value 0 and stall=0.
